// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns, one 32-bit column per clock through a single shared
// column multiplier; holds one 128-bit state at a time with valid/ready on both sides.
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state_r;
    logic [1:0]   col_r;
    logic [127:0] data_r;
    logic [127:0] result_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;
    logic [31:0]  col_in_s;
    logic [31:0]  col_out_s;

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Full column transform: rows of {2,3,1,1} rotated per output byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        mix_col = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                   a0 ^ x1 ^ x2 ^ a2 ^ a3,
                   a0 ^ a1 ^ x2 ^ x3 ^ a3,
                   x0 ^ a0 ^ a1 ^ a2 ^ x3};
    endfunction

    // Select the held column addressed by the column counter.
    always_comb begin
        col_in_s = 32'h0000_0000;
        case (col_r)
            2'd0:    col_in_s = data_r[127:96];
            2'd1:    col_in_s = data_r[95:64];
            2'd2:    col_in_s = data_r[63:32];
            2'd3:    col_in_s = data_r[31:0];
            default: col_in_s = 32'h0000_0000;
        endcase
        col_out_s = mix_col(col_in_s);
    end

    // Control FSM, state capture and column-by-column result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            col_r       <= 2'd0;
            data_r      <= 128'h0;
            result_r    <= 128'h0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_r     <= in_data;
                        col_r      <= 2'd0;
                        state_r    <= ST_CALC;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    case (col_r)
                        2'd0:    result_r[127:96] <= col_out_s;
                        2'd1:    result_r[95:64]  <= col_out_s;
                        2'd2:    result_r[63:32]  <= col_out_s;
                        2'd3:    result_r[31:0]   <= col_out_s;
                        default: result_r         <= result_r;
                    endcase
                    // The 2-bit counter wraps to 0 on the last column.
                    col_r <= col_r + 2'd1;
                    if (col_r == 2'd3) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    col_r       <= 2'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = result_r;
    assign busy      = busy_r;

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Forward AES MixColumns unit that processes one 32-bit column per clock, so a 128-bit state takes four cycles.
- Sits in the encrypt round datapath between ShiftRows and AddRoundKey. It is the encrypt-direction counterpart of the InvMixColumns row multipliers.
- Valid/ready handshakes on input and output. Holds one state at a time; no overlap between consecutive states.

Parameters:
- none. Width is fixed at the 128-bit AES state.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid state
- in_ready  output  1  unit can accept a state
- in_data  input  128  state to transform
- out_valid  output  1  out_data holds a valid result
- out_ready  input  1  consumer accepts out_data
- out_data  output  128  MixColumns result
- busy  output  1  high while not IDLE

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high, sampled on the rising edge of clk.
- Byte mapping:
  - Column c (c = 0..3) occupies data[127-32c -: 32].
  - Within a column, bits [31:24] = row 0 (a0), [23:16] = a1, [15:8] = a2, [7:0] = a3.
- Column function, in GF(2^8) with polynomial 0x11B:
  - r0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - r1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - r2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - r3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xtime(x) ^ x.
  - One shared combinational column multiplier is used, muxed by column index.
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready, register in_data into a 128-bit state register, col <= 0, go to CALC.
  - CALC: each cycle, write column col of the result register from column col of the state register, col <= col+1. When col==3 on that edge, go to DONE.
  - DONE: out_valid=1 and out_data = result register. On out_valid & out_ready, go to IDLE.
- Output stability: out_data holds stable while out_valid=1 and out_ready=0, for an unlimited stall.
- Latency:
  - Accept edge T; columns written on edges T+1..T+4.
  - out_valid is high from after edge T+4.
  - Earliest next accept is the edge after the output handshake. Throughput is 1 state per 6 cycles at best.
- Handshake rules:
  - in_ready is combinational: in_ready = (state==IDLE). It does not depend on in_valid.
  - in_valid while not in IDLE is ignored. in_data is not sampled outside the accept edge.
  - out_valid never drops without a handshake, except on reset.
  - busy = (state != IDLE).
- Boundary cases:
  - Output handshake and new in_valid on the same edge: only the output completes. The input is accepted on the following cycle (IDLE).
  - Counter col is 2 bits and wraps 3→0 on the CALC→DONE edge.
- Reset values: state=IDLE, col=0, in_ready=1, out_valid=0, busy=0, out_data=128'h0.
- Reset mid-operation (CALC or DONE): abandon the transform and return to the reset values on the next edge. A partial result must never appear with out_valid.
- Field math: a column of all-equal bytes is a fixed point (2^3^1^1 = 1).

Test Plan:
- Reset then FIPS-197 round-1 vector: in_data=d4bf5d30e0b452aeb84111f11e2798e5, out_ready=1 -> after 4 cycles out_data=046681e5e0cb199a48f8d37a2806264c, out_valid for exactly 1 cycle, in_ready=1 the next cycle.
- Column vectors in column 0, other columns 0:
  - db135345 -> 8e4da1bc
  - f20a225c -> 9fdc589d
  - d4d4d4d5 -> d5d5d7d6
  - 2d26314c -> 4d7ebdf8
  - 01010101 and c6c6c6c6 unchanged
  - other columns of out_data remain 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1 and out_data is unchanged. Pulse in_valid with new data during the stall -> in_ready=0 and the data is ignored. Raise out_ready -> single handshake, then the new state is accepted the next cycle.
- Reset mid-CALC: assert rst at col==2 -> next cycle in_ready=1, out_valid=0, out_data=0. A fresh vector afterwards gives the correct result with no stale columns.
- Back-to-back states with out_ready=1 and in_valid held high -> accepts every 6th cycle, and results appear in input order.
- Random 10k states vs a reference model using 0x11B arithmetic, with random in_valid/out_ready -> zero mismatches, and no handshake without a prior accept.
